// File: rtl/tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_pkg
// Description : Shared state encoding and default divisors for tick_scheduler
// Revision    : 1.0 - initial release
// ============================================================================
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam int c_def_scan_div = 100000;
    localparam int c_def_fast_div = 400000;
    localparam int c_def_slow_div = 100000000;
    localparam int c_cnt_w        = 27;

endpackage
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : Modulo counter 0..limit-1 with enable, clear and wrap strobe
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
    import tick_pkg::*;
#(
    parameter int W = c_cnt_w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         wrap
);

    logic [W-1:0] r_count;

    // Clear dominates enable, so no wrap can be reported on a clearing cycle.
    assign wrap = en && !clr && (r_count == limit - W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tick_scheduler
// Description : Scan and count clock-enable generator with start/pause/step FSM
// Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int SCAN_DIV = c_def_scan_div,
    parameter int FAST_DIV = c_def_fast_div,
    parameter int SLOW_DIV = c_def_slow_div,
    parameter int CNT_W    = c_cnt_w
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pb,
    input  logic       pause_pb,
    input  logic       step_pb,
    input  logic       rate_sel,
    output logic       scan_tick,
    output logic [1:0] scan_idx,
    output logic       cnt_tick,
    output logic [1:0] state,
    output logic       running
);

    localparam logic [CNT_W-1:0] c_scan_lim = CNT_W'(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_fast_lim = CNT_W'(FAST_DIV);
    localparam logic [CNT_W-1:0] c_slow_lim = CNT_W'(SLOW_DIV);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_div_lat;
    logic [CNT_W-1:0]   w_rate_div;
    logic               w_scan_wrap;
    logic               w_cnt_wrap;
    logic               w_cnt_en;
    logic               w_cnt_clr;

    assign w_rate_div = rate_sel ? c_fast_lim : c_slow_lim;
    assign w_cnt_en   = (r_state == ST_RUN);
    assign w_cnt_clr  = (r_state == ST_IDLE) || (r_state == ST_STEP);
    assign state      = r_state;

    // Pause outranks step, step outranks start; a losing pulse is simply dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!pause_pb) begin
                    if (step_pb)       w_next = ST_STEP;
                    else if (start_pb) w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pause_pb) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_pb)      w_next = ST_RUN;
                else if (step_pb)  w_next = ST_STEP;
                else if (start_pb) w_next = ST_RUN;
            end
            ST_STEP: w_next = ST_PAUSE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= ST_IDLE;
            running   <= 1'b0;
            scan_tick <= 1'b0;
            scan_idx  <= 2'd0;
            cnt_tick  <= 1'b0;
            r_div_lat <= w_rate_div;
        end else begin
            r_state   <= w_next;
            running   <= (w_next == ST_RUN);
            scan_tick <= w_scan_wrap;
            scan_idx  <= scan_idx + {1'b0, w_scan_wrap};
            cnt_tick  <= w_cnt_wrap || (r_state == ST_STEP);
            // Rate is only re-sampled at period boundaries so periods never truncate.
            if (w_cnt_wrap || ((r_state == ST_IDLE) && (w_next == ST_RUN))) begin
                r_div_lat <= w_rate_div;
            end
        end
    end

    tick_counter #(.W(CNT_W)) u_scan_cnt (
        .clk   (clk),
        .rst   (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .limit (c_scan_lim),
        .wrap  (w_scan_wrap)
    );

    tick_counter #(.W(CNT_W)) u_count_cnt (
        .clk   (clk),
        .rst   (rst_n),
        .en    (w_cnt_en),
        .clr   (w_cnt_clr),
        .limit (r_div_lat),
        .wrap  (w_cnt_wrap)
    );

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Randomized self-checking bench for tick_scheduler
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int SCAN_DIV = 4;
    localparam int FAST_DIV = 5;
    localparam int SLOW_DIV = 8;
    localparam int CNT_W    = 27;
    localparam int c_idle   = 0;
    localparam int c_run    = 1;
    localparam int c_pause  = 2;
    localparam int c_step   = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start_pb = 1'b0;
    logic       pause_pb = 1'b0;
    logic       step_pb  = 1'b0;
    logic       rate_sel = 1'b0;
    logic       scan_tick;
    logic [1:0] scan_idx;
    logic       cnt_tick;
    logic [1:0] state;
    logic       running;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edges since reset, state, cycles left in the period.
    int m_edges;
    int m_state;
    int m_rem;
    int m_div;
    bit m_tick;
    int trans[4][4];

    tick_scheduler #(
        .SCAN_DIV (SCAN_DIV),
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_pb  (start_pb),
        .pause_pb  (pause_pb),
        .step_pb   (step_pb),
        .rate_sel  (rate_sel),
        .scan_tick (scan_tick),
        .scan_idx  (scan_idx),
        .cnt_tick  (cnt_tick),
        .state     (state),
        .running   (running)
    );

    always #5 clk = ~clk;

    function automatic bit exp_scan_tick();
        return (m_edges > 0) && (m_edges % SCAN_DIV == 0);
    endfunction

    function automatic logic [1:0] exp_scan_idx();
        return 2'((m_edges / SCAN_DIV) % 4);
    endfunction

    function automatic int rate_div();
        return rate_sel ? FAST_DIV : SLOW_DIV;
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that edge,
    // then release all one-cycle pulses.
    task automatic tick();
        int ev;
        @(posedge clk);
        if (rst_n) begin
            m_edges = 0;
            m_state = c_idle;
            m_div   = rate_div();
            m_rem   = m_div;
            m_tick  = 1'b0;
        end else begin
            m_edges++;
            m_tick = 1'b0;
            if (m_state == c_run) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_tick = 1'b1;
                    m_div  = rate_div();
                    m_rem  = m_div;
                end
            end else if (m_state == c_step) begin
                m_tick = 1'b1;
                m_rem  = m_div;
            end
            ev = pause_pb ? 1 : (step_pb ? 2 : (start_pb ? 3 : 0));
            if (m_state == c_idle && trans[c_idle][ev] == c_run) begin
                m_div = rate_div();
                m_rem = m_div;
            end
            m_state = trans[m_state][ev];
        end
        #1;
        start_pb = 1'b0;
        pause_pb = 1'b0;
        step_pb  = 1'b0;
    endtask

    task automatic wait_cnt_tick(input int limit, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (cnt_tick !== 1'b1 && gap < limit);
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        rate_sel = 1'($urandom);
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        rate_sel = 1'($urandom);
        tick();
        n_tests += 5;
        if (scan_tick !== 1'b0) begin n_fail++; $display("FAIL reset_scan_tick: got %b want 0", scan_tick); end
        if (scan_idx !== 2'd0)  begin n_fail++; $display("FAIL reset_scan_idx: got %0d want 0", scan_idx); end
        if (cnt_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_cnt_tick: got %b want 0", cnt_tick); end
        if (state !== 2'd0)     begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        if (running !== 1'b0)   begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
        rst_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            n_tests += 3;
            if (scan_tick !== exp_scan_tick()) begin
                n_fail++; $display("FAIL scan_tick@%0d: got %b want %b", m_edges, scan_tick, exp_scan_tick());
            end
            if (scan_idx !== exp_scan_idx()) begin
                n_fail++; $display("FAIL scan_idx@%0d: got %0d want %0d", m_edges, scan_idx, exp_scan_idx());
            end
            if (cnt_tick !== 1'b0) begin
                n_fail++; $display("FAIL idle_cnt_tick@%0d: got %b want 0", m_edges, cnt_tick);
            end
        end
    endtask

    task automatic test_start_fast();
        bit exp;
        do_reset();
        while (m_edges < 9) tick();
        rate_sel = 1'b1;
        start_pb = 1'b1;
        tick();
        n_tests += 2;
        if (running !== 1'b1)  begin n_fail++; $display("FAIL start_running: got %b want 1", running); end
        if (state !== 2'd1)    begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = (m_edges > 10) && ((m_edges - 10) % FAST_DIV == 0);
            n_tests++;
            if (cnt_tick !== exp) begin
                n_fail++; $display("FAIL fast_tick@%0d: got %b want %b", m_edges, cnt_tick, exp);
            end
        end
    endtask

    task automatic test_rate_change();
        int g;
        wait_cnt_tick(2 * FAST_DIV, g);
        tick();
        tick();
        rate_sel = 1'b0;
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g + 2 != FAST_DIV) begin
            n_fail++; $display("FAIL rate_change_first_gap: got %0d want %0d", g + 2, FAST_DIV);
        end
        for (int i = 0; i < 2; i++) begin
            wait_cnt_tick(2 * SLOW_DIV, g);
            n_tests++;
            if (cnt_tick !== 1'b1 || g != SLOW_DIV) begin
                n_fail++; $display("FAIL rate_change_slow_gap: got %0d want %0d", g, SLOW_DIV);
            end
        end
    endtask

    task automatic test_pause_resume();
        int g;
        int d;
        do_reset();
        rate_sel = 1'($urandom);
        d = rate_div();
        start_pb = 1'b1;
        tick();
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g != d) begin
            n_fail++; $display("FAIL pause_first_gap: got %0d want %0d", g, d);
        end
        tick();
        tick();
        pause_pb = 1'b1;
        tick();
        n_tests += 2;
        if (state !== 2'd2)   begin n_fail++; $display("FAIL pause_state: got %0d want 2", state); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", running); end
        rate_sel = ~rate_sel;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (cnt_tick !== 1'b0 || state !== 2'd2) begin
                n_fail++; $display("FAIL paused_idle@%0d: got tick %b state %0d want 0/2", m_edges, cnt_tick, state);
            end
        end
        if ($urandom_range(1, 0) == 1) pause_pb = 1'b1; else start_pb = 1'b1;
        tick();
        n_tests++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running: got %b want 1", running); end
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g != d - 3) begin
            n_fail++; $display("FAIL resume_gap: got %0d want %0d", g, d - 3);
        end
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g != rate_div()) begin
            n_fail++; $display("FAIL relatched_gap: got %0d want %0d", g, rate_div());
        end
    endtask

    task automatic test_step();
        int g;
        int d;
        d = rate_div();
        pause_pb = 1'b1;
        tick();
        step_pb  = 1'b1;
        start_pb = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd3) begin n_fail++; $display("FAIL step_state: got %0d want 3", state); end
        tick();
        n_tests += 2;
        if (state !== 2'd2)    begin n_fail++; $display("FAIL step_to_pause: got %0d want 2", state); end
        if (cnt_tick !== 1'b1) begin n_fail++; $display("FAIL step_tick: got %b want 1", cnt_tick); end
        tick();
        n_tests++;
        if (cnt_tick !== 1'b0) begin n_fail++; $display("FAIL step_single_tick: got %b want 0", cnt_tick); end
        start_pb = 1'b1;
        tick();
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g != d) begin
            n_fail++; $display("FAIL post_step_gap: got %0d want %0d", g, d);
        end
        d = rate_div();
        for (int i = 0; i < d - 1; i++) tick();
        pause_pb = 1'b1;
        tick();
        n_tests += 2;
        if (cnt_tick !== 1'b1) begin n_fail++; $display("FAIL wrap_with_pause_tick: got %b want 1", cnt_tick); end
        if (state !== 2'd2)    begin n_fail++; $display("FAIL wrap_with_pause_state: got %0d want 2", state); end
        d = rate_div();
        start_pb = 1'b1;
        tick();
        wait_cnt_tick(2 * SLOW_DIV, g);
        n_tests++;
        if (cnt_tick !== 1'b1 || g != d) begin
            n_fail++; $display("FAIL held_zero_gap: got %0d want %0d", g, d);
        end
        pause_pb = 1'b1;
        start_pb = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL pause_beats_start: got %0d want 2", state); end
    endtask

    task automatic test_reset_mid_run();
        int g;
        do_reset();
        start_pb = 1'b1;
        tick();
        wait_cnt_tick(2 * SLOW_DIV, g);
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({scan_tick, scan_idx, cnt_tick, state, running} !== 7'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b want 0", {scan_tick, scan_idx, cnt_tick, state, running});
        end
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if (cnt_tick !== 1'b0 || state !== 2'd0 || scan_tick !== exp_scan_tick()) begin
                n_fail++; $display("FAIL post_reset@%0d: got tick %b state %0d scan %b want 0/0/%b",
                                   m_edges, cnt_tick, state, scan_tick, exp_scan_tick());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            start_pb = ($urandom_range(5, 0) == 0);
            pause_pb = ($urandom_range(7, 0) == 0);
            step_pb  = ($urandom_range(7, 0) == 0);
            if ($urandom_range(9, 0) == 0) rate_sel = ~rate_sel;
            rst_n = ($urandom_range(199, 0) == 0);
            tick();
            n_tests += 5;
            if (cnt_tick !== m_tick) begin
                n_fail++; $display("FAIL rnd_cnt_tick@%0d: got %b want %b", i, cnt_tick, m_tick);
            end
            if (state !== 2'(m_state)) begin
                n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", i, state, m_state);
            end
            if (running !== (m_state == c_run)) begin
                n_fail++; $display("FAIL rnd_running@%0d: got %b want %b", i, running, m_state == c_run);
            end
            if (scan_tick !== exp_scan_tick()) begin
                n_fail++; $display("FAIL rnd_scan_tick@%0d: got %b want %b", i, scan_tick, exp_scan_tick());
            end
            if (scan_idx !== exp_scan_idx()) begin
                n_fail++; $display("FAIL rnd_scan_idx@%0d: got %0d want %0d", i, scan_idx, exp_scan_idx());
            end
        end
        rst_n = 1'b0;
    endtask

    initial begin
        // Next state indexed by [state][event]; events: none, pause, step, start.
        trans[c_idle]  = '{c_idle,  c_idle,  c_step,  c_run};
        trans[c_run]   = '{c_run,   c_pause, c_run,   c_run};
        trans[c_pause] = '{c_pause, c_run,   c_step,  c_run};
        trans[c_step]  = '{c_pause, c_pause, c_pause, c_pause};
        m_edges = 0;
        m_state = c_idle;
        m_rem   = SLOW_DIV;
        m_div   = SLOW_DIV;
        m_tick  = 1'b0;

        test_reset();
        test_start_fast();
        test_rate_change();
        test_pause_resume();
        test_step();
        test_reset_mid_run();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
